// File: rtl/demux_stream_pkg.sv
// Shared constants and helpers for the 1-to-N stream demultiplexer.
package demux_stream_pkg;

   // Upper bounds accepted by the elaboration checks in the top level.
   localparam int MAX_NUM_OUT = 64;
   localparam int MAX_DATA_W  = 256;

   // Width of a binary index able to address n entries, never less than one bit.
   function automatic int clog2_min1(input int n);
      int r;
      r = 1;
      for (int i = 1; i < 31; i++) begin
         if (int'(32'd1 << i) < n) begin
            r = i + 1;
         end else begin
            r = r;
         end
      end
      return r;
   endfunction

   // Even parity over a select value, available for protected select paths.
   function automatic logic sel_parity(input logic [7:0] sel);
      return ^sel;
   endfunction

endpackage : demux_stream_pkg

// File: rtl/demux_slot.sv
// One-entry output register for a single demux channel. It holds at most one
// beat, reloads in the same cycle it drains, and keeps the last payload after
// the beat has been taken.
module demux_slot
   import demux_stream_pkg::*;
#(
   parameter int DATA_W = 8
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              load_i,
   input  logic [DATA_W-1:0] data_i,
   input  logic              ready_i,
   output logic              valid_o,
   output logic [DATA_W-1:0] data_o,
   output logic              can_load_o
);

   logic              valid_q;
   logic              valid_d;
   logic [DATA_W-1:0] data_q;
   logic [DATA_W-1:0] data_d;

   // Next-state of the slot: a load wins over a drain so a simultaneous
   // drain and load keeps the slot occupied with the new beat.
   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      if (load_i) begin
         valid_d = 1'b1;
         data_d  = data_i;
      end else if (valid_q && ready_i) begin
         valid_d = 1'b0;
      end else begin
         valid_d = valid_q;
      end
   end

   // Slot register; reset discards any held beat and clears the payload.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         valid_q <= 1'b0;
         data_q  <= {DATA_W{1'b0}};
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
      end
   end

   // A slot can take a new beat when it is empty or is being emptied now.
   assign can_load_o = ~valid_q | ready_i;
   assign valid_o    = valid_q;
   assign data_o     = data_q;

endmodule : demux_slot

// File: rtl/demux_stream_1ton.sv
// Registered 1-to-NUM_OUT stream demultiplexer. One producer is routed to one
// of NUM_OUT independently drained one-entry channels selected by a binary
// index. Beats addressed past the last channel are consumed, flagged with a
// one-cycle error pulse and counted by a saturating drop counter.
module demux_stream_1ton
   import demux_stream_pkg::*;
#(
   parameter int NUM_OUT = 8,
   parameter int DATA_W  = 8,
   parameter int SEL_W   = clog2_min1(NUM_OUT),
   parameter int CNT_W   = 16
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic [DATA_W-1:0]         in_data_i,
   input  logic [SEL_W-1:0]          in_sel_i,
   input  logic                      in_valid_i,
   output logic                      in_ready_o,
   output logic [NUM_OUT*DATA_W-1:0] out_data_o,
   output logic [NUM_OUT-1:0]        out_valid_o,
   input  logic [NUM_OUT-1:0]        out_ready_i,
   output logic                      sel_err_o,
   output logic [CNT_W-1:0]          drop_cnt_o
);

   // ------------------------------------------------------------------
   // Elaboration-time parameter checks
   // ------------------------------------------------------------------
   if ((NUM_OUT < 2) || (NUM_OUT > MAX_NUM_OUT)) begin : g_bad_num_out
      $error("demux_stream_1ton: NUM_OUT=%0d outside 2..%0d", NUM_OUT, MAX_NUM_OUT);
   end
   if ((DATA_W < 1) || (DATA_W > MAX_DATA_W)) begin : g_bad_data_w
      $error("demux_stream_1ton: DATA_W=%0d outside 1..%0d", DATA_W, MAX_DATA_W);
   end
   if (SEL_W != clog2_min1(NUM_OUT)) begin : g_bad_sel_w
      $error("demux_stream_1ton: SEL_W=%0d must equal %0d", SEL_W, clog2_min1(NUM_OUT));
   end
   if (CNT_W < 1) begin : g_bad_cnt_w
      $error("demux_stream_1ton: CNT_W=%0d must be at least 1", CNT_W);
   end

   // ------------------------------------------------------------------
   // Declarations
   // ------------------------------------------------------------------
   logic               sel_legal_s;
   logic               sel_ready_s;
   logic               in_ready_s;
   logic               accept_s;
   logic               drop_s;
   logic [NUM_OUT-1:0] load_s;
   logic [NUM_OUT-1:0] can_load_s;

   logic               sel_err_q;
   logic               sel_err_d;
   logic [CNT_W-1:0]   drop_cnt_q;
   logic [CNT_W-1:0]   drop_cnt_d;

   // A select is legal when it names an existing channel; for non-power-of-two
   // channel counts the upper select codes are illegal.
   assign sel_legal_s = ({1'b0, in_sel_i} < (SEL_W+1)'(NUM_OUT));

   // Pick the load capability of the addressed slot without indexing past
   // the channel vector when the select is illegal.
   always_comb begin
      sel_ready_s = 1'b0;
      for (int k = 0; k < NUM_OUT; k++) begin
         if (in_sel_i == SEL_W'(k)) begin
            sel_ready_s = can_load_s[k];
         end else begin
            sel_ready_s = sel_ready_s;
         end
      end
   end

   // Producer-side ready: held low during reset, always high for illegal
   // selects so that they never stall the producer.
   always_comb begin
      if (rst_i) begin
         in_ready_s = 1'b0;
      end else if (sel_legal_s) begin
         in_ready_s = sel_ready_s;
      end else begin
         in_ready_s = 1'b1;
      end
   end

   assign in_ready_o = in_ready_s;
   assign accept_s   = in_valid_i & in_ready_s & sel_legal_s;
   assign drop_s     = in_valid_i & in_ready_s & ~sel_legal_s;

   // One-hot load strobe toward the addressed slot for an accepted legal beat.
   always_comb begin
      load_s = {NUM_OUT{1'b0}};
      for (int k = 0; k < NUM_OUT; k++) begin
         if (accept_s && (in_sel_i == SEL_W'(k))) begin
            load_s[k] = 1'b1;
         end else begin
            load_s[k] = 1'b0;
         end
      end
   end

   // ------------------------------------------------------------------
   // Per-channel slots
   // ------------------------------------------------------------------
   for (genvar k = 0; k < NUM_OUT; k++) begin : g_slot
      demux_slot #(
         .DATA_W (DATA_W)
      ) u_slot (
         .clk_i      (clk_i),
         .rst_i      (rst_i),
         .load_i     (load_s[k]),
         .data_i     (in_data_i),
         .ready_i    (out_ready_i[k]),
         .valid_o    (out_valid_o[k]),
         .data_o     (out_data_o[k*DATA_W +: DATA_W]),
         .can_load_o (can_load_s[k])
      );
   end

   // ------------------------------------------------------------------
   // Illegal-select reporting
   // ------------------------------------------------------------------

   // Next error pulse and saturating drop count.
   always_comb begin
      sel_err_d  = drop_s;
      drop_cnt_d = drop_cnt_q;
      if (drop_s && (drop_cnt_q != {CNT_W{1'b1}})) begin
         drop_cnt_d = drop_cnt_q + CNT_W'(1'b1);
      end else begin
         drop_cnt_d = drop_cnt_q;
      end
   end

   // Error pulse and drop counter registers.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sel_err_q  <= 1'b0;
         drop_cnt_q <= {CNT_W{1'b0}};
      end else begin
         sel_err_q  <= sel_err_d;
         drop_cnt_q <= drop_cnt_d;
      end
   end

   assign sel_err_o  = sel_err_q;
   assign drop_cnt_o = drop_cnt_q;

endmodule : demux_stream_1ton

// File: tb/tb_demux_stream_1ton.sv
// Directed and randomized bench for demux_stream_1ton with a behavioural
// per-channel reference model.
module tb_demux_stream_1ton;

   localparam int N  = 6;
   localparam int DW = 8;
   localparam int CW = 4;
   localparam int SW = 3;

   logic            clk = 1'b0;
   logic            rst;
   logic [DW-1:0]   in_data;
   logic [SW-1:0]   in_sel;
   logic            in_valid;
   logic            in_ready;
   logic [N*DW-1:0] out_data;
   logic [N-1:0]    out_valid;
   logic [N-1:0]    out_ready;
   logic            sel_err;
   logic [CW-1:0]   drop_cnt;

   int checks = 0;
   int errors = 0;
   int acc    = 0;

   // Reference model state: one entry per channel.
   logic          m_v [N];
   logic [DW-1:0] m_d [N];
   logic          m_err;
   logic [CW-1:0] m_cnt;

   always #5 clk = ~clk;

   demux_stream_1ton #(
      .NUM_OUT (N),
      .DATA_W  (DW),
      .CNT_W   (CW)
   ) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .in_data_i   (in_data),
      .in_sel_i    (in_sel),
      .in_valid_i  (in_valid),
      .in_ready_o  (in_ready),
      .out_data_o  (out_data),
      .out_valid_o (out_valid),
      .out_ready_i (out_ready),
      .sel_err_o   (sel_err),
      .drop_cnt_o  (drop_cnt)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   // Drive one cycle of inputs, check ready before the edge, advance the
   // model across the edge and check every registered output after it.
   task automatic step(input logic r, input logic v, input logic [SW-1:0] s,
                       input logic [DW-1:0] d, input logic [N-1:0] ordy);
      logic          exp_rdy;
      logic          fire;
      logic [N-1:0]  ev;
      logic [N*DW-1:0] ed;
      rst = r; in_valid = v; in_sel = s; in_data = d; out_ready = ordy;
      #1;
      if (r)                exp_rdy = 1'b0;
      else if (int'(s) < N) exp_rdy = !m_v[s] || ordy[s];
      else                  exp_rdy = 1'b1;
      chk("in_ready", {63'd0, in_ready}, {63'd0, exp_rdy});
      if (in_ready === 1'b1 && v) acc++;
      fire = v && exp_rdy;
      @(posedge clk);
      #1;
      if (r) begin
         for (int k = 0; k < N; k++) begin m_v[k] = 1'b0; m_d[k] = '0; end
         m_err = 1'b0;
         m_cnt = '0;
      end else begin
         for (int k = 0; k < N; k++) begin
            if (fire && int'(s) == k) begin m_v[k] = 1'b1; m_d[k] = d; end
            else if (m_v[k] && ordy[k]) m_v[k] = 1'b0;
         end
         m_err = fire && (int'(s) >= N);
         if (m_err && m_cnt != 4'hF) m_cnt = m_cnt + 4'd1;
      end
      for (int k = 0; k < N; k++) begin
         ev[k] = m_v[k];
         ed[k*DW +: DW] = m_d[k];
      end
      chk("out_valid", {58'd0, out_valid}, {58'd0, ev});
      chk("out_data", {16'd0, out_data}, {16'd0, ed});
      chk("sel_err", {63'd0, sel_err}, {63'd0, m_err});
      chk("drop_cnt", {60'd0, drop_cnt}, {60'd0, m_cnt});
   endtask

   initial begin
      for (int k = 0; k < N; k++) begin m_v[k] = 1'b0; m_d[k] = '0; end
      m_err = 1'b0; m_cnt = '0;
      rst = 1'b1; in_valid = 1'b1; in_sel = 3'd0; in_data = 8'h00; out_ready = 6'd0;
      @(posedge clk);
      #1;

      // Reset held two cycles with the producer asserting valid.
      step(1'b1, 1'b1, 3'd1, 8'h11, 6'd0);
      step(1'b1, 1'b1, 3'd3, 8'h33, 6'd0);

      // Route one beat to every channel with all consumers stalled.
      for (int k = 0; k < N; k++) step(1'b0, 1'b1, 3'(k), 8'hA0 + 8'(k), 6'd0);
      chk("route_all_valid", {58'd0, out_valid}, 64'h3F);
      chk("route_ch5", {56'd0, out_data[5*DW +: DW]}, 64'hA5);

      // Backpressure on channel 2, then release for a same-cycle reload.
      step(1'b0, 1'b1, 3'd2, 8'h55, 6'd0);
      chk("bp_hold", {56'd0, out_data[2*DW +: DW]}, 64'hA2);
      step(1'b0, 1'b1, 3'd2, 8'h55, 6'b000100);
      chk("bp_reload", {56'd0, out_data[2*DW +: DW]}, 64'h55);

      // Channel 4 streams at full rate while channel 2 stays stalled.
      acc = 0;
      for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 3'd4, 8'($urandom), 6'b010000);
      chk("ch4_rate", 64'(acc), 64'd8);

      // Illegal selects: always consumed, pulse each time, counter saturates.
      for (int i = 0; i < 17; i++) step(1'b0, 1'b1, 3'd6 + 3'(i % 2), 8'($urandom), 6'd0);
      chk("drop_sat", {60'd0, drop_cnt}, 64'hF);

      // Randomized traffic with occasional resets.
      for (int i = 0; i < 400; i++) begin
         step(($urandom_range(0, 49) == 0), 1'($urandom), 3'($urandom_range(0, 7)),
              8'($urandom), 6'($urandom));
      end

      // Reset while three slots hold beats.
      step(1'b0, 1'b0, 3'd0, 8'h00, 6'h3F);
      step(1'b0, 1'b1, 3'd0, 8'hC0, 6'd0);
      step(1'b0, 1'b1, 3'd1, 8'hC1, 6'd0);
      step(1'b0, 1'b1, 3'd3, 8'hC3, 6'd0);
      chk("pre_rst_valid", {58'd0, out_valid}, 64'h0B);
      step(1'b1, 1'b1, 3'd2, 8'hEE, 6'd0);
      chk("mid_rst_valid", {58'd0, out_valid}, 64'h00);
      step(1'b0, 1'b0, 3'd2, 8'hEE, 6'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_demux_stream_1ton
